// File: rtl/counter_sequencer.sv
// counter_sequencer: drives one 4-bit up/down counter through programmed sweeps.
// It loads start_val, counts to end_val and then either reverses (pingpong) or
// reloads start_val, for reps sweeps. The host sees a start/busy/done handshake.
// Optional build macro SEQ_DWELL_EN: when defined, the pause at each sweep
// endpoint (TURN) lasts DWELL cycles instead of one.
module counter_sequencer #(
   parameter int WIDTH = 4,
   parameter int REP_W = 8,
   parameter int DWELL = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] end_val,
   input  logic [REP_W-1:0] reps,
   input  logic             pingpong,
   input  logic [WIDTH-1:0] ctr_count,
   output logic             ctr_load,
   output logic             ctr_enable,
   output logic             ctr_up_down,
   output logic [WIDTH-1:0] ctr_d_in,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] sweeps_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_TURN,
      S_DONE
   } state_t;

   // Dwell counter width; it collapses to a constant-zero bit when the
   // dwell feature is not built in.
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

`ifdef SEQ_DWELL_EN
   localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL - 1);
`else
   localparam logic [DW_W-1:0] DWELL_LOAD = '0;
`endif

   state_t           state_q;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] end_q;
   logic [WIDTH-1:0] target_q;
   logic [REP_W-1:0] reps_q;
   logic [REP_W-1:0] sweeps_q;
   logic [REP_W-1:0] sweeps_d;
   logic [DW_W-1:0]  dwell_q;
   logic             pp_q;
   logic             dir_q;
   logic             to_end_q;
   logic             load_q;
   logic             run_q;
   logic             busy_q;
   logic             done_q;
   logic             at_target;
   logic             last_sweep;
   logic             dwell_over;

   assign at_target  = (ctr_count == target_q);
   assign sweeps_d   = sweeps_q + 1'b1;
   assign last_sweep = (sweeps_d == reps_q);
   assign dwell_over = (dwell_q == '0);

   // Abort must stop the counter in the very cycle it is raised, so the
   // registered load/run flags are gated combinationally. Enable also drops
   // as soon as the count reaches the target so the counter stops on it.
   assign ctr_load    = load_q & ~abort;
   assign ctr_enable  = run_q & ~at_target & ~abort;
   assign ctr_up_down = dir_q;
   assign ctr_d_in    = start_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sweeps_done = sweeps_q;

   // Sequencer FSM: state, latched operands, sweep bookkeeping and output flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         start_q  <= '0;
         end_q    <= '0;
         target_q <= '0;
         reps_q   <= '0;
         sweeps_q <= '0;
         dwell_q  <= '0;
         pp_q     <= 1'b0;
         dir_q    <= 1'b0;
         to_end_q <= 1'b0;
         load_q   <= 1'b0;
         run_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (abort && (state_q != S_IDLE)) begin
         // Counter keeps its value and sweeps_done is preserved for the host.
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         load_q <= 1'b0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  start_q  <= start_val;
                  end_q    <= end_val;
                  reps_q   <= (reps == '0) ? REP_W'(1) : reps;
                  pp_q     <= pingpong;
                  sweeps_q <= '0;
                  load_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Every load (first or reload) heads toward end_val.
               target_q <= end_q;
               to_end_q <= 1'b1;
               dir_q    <= (end_q > start_q);
               run_q    <= 1'b1;
               state_q  <= S_RUN;
            end
            S_RUN: begin
               if (at_target) begin
                  sweeps_q <= sweeps_d;
                  if (last_sweep) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     dwell_q <= DWELL_LOAD;
                     state_q <= S_TURN;
                  end
               end else begin
                  run_q <= 1'b1;
               end
            end
            S_TURN: begin
               if (dwell_over) begin
                  if (pp_q) begin
                     // Reverse: the new target is the opposite endpoint, and
                     // since the count sits on the old one, direction flips.
                     target_q <= to_end_q ? start_q : end_q;
                     to_end_q <= ~to_end_q;
                     dir_q    <= ~dir_q;
                     run_q    <= 1'b1;
                     state_q  <= S_RUN;
                  end else begin
                     load_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end
               end else begin
                  dwell_q <= dwell_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: drives sweeps into a behavioural up/down
// counter and compares the count sequence against a reference sweep model.
module tb_counter_sequencer;

   localparam int WIDTH = 4;
   localparam int REP_W = 8;
   localparam int DWELL = 3;
`ifdef SEQ_DWELL_EN
   localparam int DW_EXTRA = DWELL - 1;
`else
   localparam int DW_EXTRA = 0;
`endif

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] end_val;
   logic [REP_W-1:0] reps;
   logic             pingpong;
   logic [WIDTH-1:0] cnt;
   logic             ctr_load;
   logic             ctr_enable;
   logic             ctr_up_down;
   logic [WIDTH-1:0] ctr_d_in;
   logic             busy;
   logic             done;
   logic [REP_W-1:0] sweeps_done;
   logic             ctr_rst_n;

   int vectors     = 0;
   int miscompares = 0;
   int exp_q[$];
   int exp_final;

   counter_sequencer #(
      .WIDTH(WIDTH),
      .REP_W(REP_W),
      .DWELL(DWELL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .start_val  (start_val),
      .end_val    (end_val),
      .reps       (reps),
      .pingpong   (pingpong),
      .ctr_count  (cnt),
      .ctr_load   (ctr_load),
      .ctr_enable (ctr_enable),
      .ctr_up_down(ctr_up_down),
      .ctr_d_in   (ctr_d_in),
      .busy       (busy),
      .done       (done),
      .sweeps_done(sweeps_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 4-bit up/down counter with active-low reset.
   assign ctr_rst_n = !rst;
   always_ff @(posedge clk) begin
      if (!ctr_rst_n)      cnt <= '0;
      else if (ctr_load)   cnt <= ctr_d_in;
      else if (ctr_enable) cnt <= ctr_up_down ? cnt + 1'b1 : cnt - 1'b1;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: every value the counter takes after a load or a step.
   task automatic push_expected(input int s, input int e, input int rr, input bit pp);
      int cur;
      int tgt;
      bit to_end;
      exp_q.delete();
      cur    = s;
      to_end = 1'b1;
      exp_q.push_back(s);
      for (int k = 0; k < rr; k++) begin
         if (k > 0) begin
            if (pp) to_end = !to_end;
            else begin
               cur = s;
               exp_q.push_back(s);
            end
         end
         tgt = to_end ? e : s;
         while (cur != tgt) begin
            cur = (tgt > cur) ? cur + 1 : cur - 1;
            exp_q.push_back(cur);
         end
      end
      exp_final = cur;
   endtask

   task automatic sb_pop(input int got);
      int e;
      if (exp_q.size() == 0) check_val("count_extra", got, -1);
      else begin
         e = exp_q.pop_front();
         check_val("count", got, e);
      end
   endtask

   // Full run: latency, done pulse, loads, sweep count and count sequence.
   task automatic run_seq(input int s, input int e, input int r, input bit pp, input bit poke);
      int rr, n, exp_lat, lat, dones, loads;
      bit step;
      rr      = (r == 0) ? 1 : r;
      n       = (e > s) ? e - s : s - e;
      exp_lat = pp ? (n + 2) * rr : (n + 2) + (rr - 1) * (n + 3);
      exp_lat = exp_lat + (rr - 1) * DW_EXTRA;
      push_expected(s, e, rr, pp);
      @(negedge clk);
      start_val = WIDTH'(s);
      end_val   = WIDTH'(e);
      reps      = REP_W'(r);
      pingpong  = pp;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = -1;
      dones = 0;
      loads = 0;
      step  = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (step) sb_pop(cnt);
         step = ctr_load | ctr_enable;
         if (ctr_load) loads++;
         if (done) begin
            dones++;
            if (lat < 0) lat = cyc;
         end
         if (poke && cyc == 3) begin
            start     = 1'b1;
            start_val = WIDTH'(15 - s);
            end_val   = WIDTH'(15 - e);
            reps      = REP_W'(7);
            pingpong  = !pp;
         end else if (poke && cyc == 5) begin
            start = 1'b0;
         end
         if (lat >= 0 && cyc >= lat + 3) break;
         @(negedge clk);
      end
      start = 1'b0;
      if (lat < 0) check_val("done_timeout", 0, 1);
      else check_val("done_latency", lat, exp_lat);
      check_val("done_pulses", dones, 1);
      check_val("load_pulses", loads, pp ? 1 : rr);
      check_val("sweeps_done", sweeps_done, rr);
      check_val("busy_after", busy, 0);
      check_val("final_count", cnt, exp_final);
      check_val("sb_leftover", exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_load"}, ctr_load, 0);
      check_val({tag, "_enable"}, ctr_enable, 0);
      check_val({tag, "_updown"}, ctr_up_down, 0);
      check_val({tag, "_d_in"}, ctr_d_in, 0);
      check_val({tag, "_sweeps"}, sweeps_done, 0);
   endtask

   initial begin
      bit step;
      bit hit;
      int dones;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      start_val = '0;
      end_val   = '0;
      reps      = '0;
      pingpong  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      run_seq(2, 6, 1, 1'b1, 1'b0);
      run_seq(3, 1, 3, 1'b1, 1'b0);
      run_seq(0, 2, 2, 1'b0, 1'b0);
      run_seq(9, 9, 0, 1'b1, 1'b0);
      run_seq(1, 7, 2, 1'b1, 1'b1);

      // abort together with start in IDLE: start is ignored
      @(negedge clk);
      start_val = 4'd4;
      end_val   = 4'd8;
      reps      = 8'd1;
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_val("abort_start_busy", busy, 0);
      check_val("abort_start_load", ctr_load, 0);

      // abort mid-run at count 5 during a 0 -> F sweep
      push_expected(0, 15, 1, 1'b1);
      @(negedge clk);
      start_val = 4'd0;
      end_val   = 4'd15;
      reps      = 8'd1;
      pingpong  = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      step  = 1'b0;
      hit   = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (step) sb_pop(cnt);
         if (!ctr_load && cnt == 4'd5) begin
            hit = 1'b1;
            check_val("pre_abort_enable", ctr_enable, 1);
            abort = 1'b1;
            #1;
            check_val("abort_enable", ctr_enable, 0);
            check_val("abort_load", ctr_load, 0);
            break;
         end
         step = ctr_load | ctr_enable;
         @(negedge clk);
      end
      if (!hit) check_val("abort_timeout", 0, 1);
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_busy", busy, 0);
      check_val("abort_count", cnt, 5);
      dones = 0;
      repeat (4) begin
         if (done) dones++;
         @(negedge clk);
      end
      check_val("abort_no_done", dones, 0);
      check_val("abort_count_hold", cnt, 5);
      check_val("abort_sweeps", sweeps_done, 0);
      exp_q.delete();

      // reset mid-run: 0 -> A ping-pong, reset on the way back at count 4
      push_expected(0, 10, 2, 1'b1);
      @(negedge clk);
      start_val = 4'd0;
      end_val   = 4'd10;
      reps      = 8'd2;
      pingpong  = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      step  = 1'b0;
      hit   = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (step) sb_pop(cnt);
         if (!ctr_load && cnt == 4'd4 && sweeps_done == 8'd1) begin
            hit = 1'b1;
            check_val("pre_reset_sweeps", sweeps_done, 1);
            rst = 1'b1;
            break;
         end
         step = ctr_load | ctr_enable;
         @(negedge clk);
      end
      if (!hit) check_val("reset_timeout", 0, 1);
      @(negedge clk);
      check_all_zero("midreset");
      check_val("midreset_count", cnt, 0);
      rst = 1'b0;
      exp_q.delete();

      run_seq(5, 3, 2, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
